// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU op codes and STATUS bit positions.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;

  // ALU operation codes presented by the decoder
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_AND  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h03;
  localparam logic [7:0] ALU_EOR  = 8'h04;
  localparam logic [7:0] ALU_ASL  = 8'h05;
  localparam logic [7:0] ALU_LSR  = 8'h06;
  localparam logic [7:0] ALU_ROL  = 8'h07;
  localparam logic [7:0] ALU_ROR  = 8'h08;
  localparam logic [7:0] ALU_INC  = 8'h09;
  localparam logic [7:0] ALU_DEC  = 8'h0A;
  localparam logic [7:0] ALU_CMP  = 8'h0B;
  localparam logic [7:0] ALU_BIT  = 8'h0C;
  localparam logic [7:0] ALU_PASS = 8'h0D;

  // STATUS register bit indices (bit 5 unused)
  localparam int CARRY = 0;
  localparam int ZERO  = 1;
  localparam int IRQ   = 2;
  localparam int DEC   = 3;
  localparam int BRK   = 4;
  localparam int OVF   = 6;
  localparam int NEG   = 7;

endpackage

// File: rtl/nes_alu_if.sv
// Decoder <-> ALU bundle: operation request inputs and registered results.
interface nes_alu_if;
  import cpu_pkg::*;

  logic [7:0]            func;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  invert;
  logic                  carry_in;
  logic [7:0]            status_in;
  logic [DATA_WIDTH-1:0] dout;
  logic [7:0]            status_out;
  logic                  wout;

  // Decoder side: issues operations, observes results
  modport master (
    output func, a_in, b_in, invert, carry_in, status_in,
    input  dout, status_out, wout
  );

  // ALU side
  modport slave (
    input  func, a_in, b_in, invert, carry_in, status_in,
    output dout, status_out, wout
  );
endinterface

// File: rtl/nes_alu_adder.sv
// Combinational 8-bit adder with carry-out and signed overflow.
module nes_alu_adder
  import cpu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow
);

  logic [DATA_WIDTH:0] full;

  // Widen by one bit so the carry out falls into the MSB
  always_comb begin
    full      = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    sum       = full[DATA_WIDTH-1:0];
    carry_out = full[DATA_WIDTH];
    // Overflow: both operands share a sign that the result does not
    overflow  = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  end

endmodule

// File: rtl/nes_alu.sv
// 6502-style ALU (no decimal mode): one registered result and flag update per
// valid op code, with a done strobe held high for each valid cycle.
module nes_alu
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  nes_alu_if.slave      bus
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic                  cin;
  logic [DATA_WIDTH-1:0] add_a, add_b, add_sum;
  logic                  add_cin, add_cout, add_ovf;
  logic [DATA_WIDTH-1:0] res;
  logic [7:0]            st;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [7:0]            status_q;
  logic                  wout_q;

  // Operand conditioning and adder input selection (shared by ADD/CMP/INC/DEC)
  always_comb begin
    b_eff   = bus.invert ? ~bus.b_in : bus.b_in;
    cin     = bus.carry_in & bus.status_in[CARRY];
    add_a   = bus.a_in;
    add_b   = b_eff;
    add_cin = cin;
    case (bus.func)
      // CMP ignores invert/carry_in: always a two's-complement subtract
      ALU_CMP: begin add_b = ~bus.b_in;              add_cin = 1'b1; end
      ALU_INC: begin add_b = '0;                     add_cin = 1'b1; end
      ALU_DEC: begin add_b = {DATA_WIDTH{1'b1}};     add_cin = 1'b0; end
      default: ;
    endcase
  end

  nes_alu_adder u_adder (
    .a         (add_a),
    .b         (add_b),
    .cin       (add_cin),
    .sum       (add_sum),
    .carry_out (add_cout),
    .overflow  (add_ovf)
  );

  // Result and flag computation; unlisted status bits pass through
  always_comb begin
    valid = 1'b1;
    res   = dout_q;
    st    = bus.status_in;
    case (bus.func)
      ALU_ADD:  begin res = add_sum; st[CARRY] = add_cout; st[OVF] = add_ovf; end
      ALU_AND:  res = bus.a_in & b_eff;
      ALU_OR:   res = bus.a_in | b_eff;
      ALU_EOR:  res = bus.a_in ^ b_eff;
      ALU_ASL:  begin res = {bus.a_in[6:0], 1'b0};                st[CARRY] = bus.a_in[7]; end
      ALU_LSR:  begin res = {1'b0, bus.a_in[7:1]};                st[CARRY] = bus.a_in[0]; end
      ALU_ROL:  begin res = {bus.a_in[6:0], bus.status_in[CARRY]}; st[CARRY] = bus.a_in[7]; end
      ALU_ROR:  begin res = {bus.status_in[CARRY], bus.a_in[7:1]}; st[CARRY] = bus.a_in[0]; end
      ALU_INC:  res = add_sum;
      ALU_DEC:  res = add_sum;
      ALU_CMP:  begin res = add_sum; st[CARRY] = add_cout; end
      ALU_BIT:  res = bus.a_in;
      ALU_PASS: res = b_eff;
      default:  valid = 1'b0;
    endcase
    st[NEG]  = res[7];
    st[ZERO] = (res == '0);
    // BIT reports memory-operand bits rather than the result
    if (bus.func == ALU_BIT) begin
      st[ZERO] = ((bus.a_in & bus.b_in) == '0);
      st[NEG]  = bus.b_in[7];
      st[OVF]  = bus.b_in[6];
    end
  end

  // Output registers: load on valid op, hold otherwise; reset clears all
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q   <= '0;
      status_q <= '0;
      wout_q   <= 1'b0;
    end else begin
      wout_q <= valid;
      if (valid) begin
        dout_q   <= res;
        status_q <= st;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.status_out = status_q;
  assign bus.wout       = wout_q;

endmodule

// File: tb/tb_nes_alu.sv
// Randomized scoreboard bench for nes_alu against an arithmetic reference model.
module tb_nes_alu;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic [7:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t m;

  nes_alu_if bus ();

  nes_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic straight from the op definitions
  function automatic exp_t model(input logic rst, input logic [7:0] f,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic inv, input logic cen,
                                 input logic [7:0] st, input exp_t prev);
    exp_t e;
    int   bp, ci, s, sv, r;
    logic [7:0] o;
    bit   ok;
    bp = inv ? int'(8'(~b)) : int'(b);
    ci = (cen && st[0]) ? 1 : 0;
    o  = st;
    ok = 1;
    r  = 0;
    if (rst) begin
      e.w = 0; e.d = 8'h00; e.s = 8'h00;
      return e;
    end
    case (f)
      8'h01: begin
        s = int'(a) + bp + ci; r = s % 256; o[0] = (s > 255);
        sv = int'($signed(a)) + int'($signed(8'(bp))) + ci;
        o[6] = (sv > 127) || (sv < -128);
      end
      8'h02: r = int'(a) & bp;
      8'h03: r = int'(a) | bp;
      8'h04: r = int'(a) ^ bp;
      8'h05: begin r = (int'(a) * 2) % 256; o[0] = (a >= 128); end
      8'h06: begin r = int'(a) / 2; o[0] = (a % 2 == 1); end
      8'h07: begin r = (int'(a) * 2 + int'(st[0])) % 256; o[0] = (a >= 128); end
      8'h08: begin r = int'(a) / 2 + 128 * int'(st[0]); o[0] = (a % 2 == 1); end
      8'h09: r = (int'(a) + 1) % 256;
      8'h0A: r = (int'(a) + 255) % 256;
      8'h0B: begin r = (int'(a) - int'(b) + 256) % 256; o[0] = (a >= b); end
      8'h0C: r = int'(a);
      8'h0D: r = bp;
      default: ok = 0;
    endcase
    if (!ok) begin
      e.w = 0; e.d = prev.d; e.s = prev.s;
      return e;
    end
    o[7] = (r >= 128);
    o[1] = (r == 0);
    if (f == 8'h0C) begin
      o[1] = ((a & b) == 8'h00);
      o[7] = b[7];
      o[6] = b[6];
    end
    e.w = 1; e.d = 8'(r); e.s = o;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the expected post-edge outputs
  task automatic drive(input logic rst, input logic [7:0] f, input logic [7:0] a,
                       input logic [7:0] b, input logic inv, input logic cen,
                       input logic [7:0] st, input exp_t e);
    @(negedge clk);
    reset         = rst;
    bus.func      = f;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.invert    = inv;
    bus.carry_in  = cen;
    bus.status_in = st;
    sb.push_back(e);
    m = e;
  endtask

  function automatic exp_t mk(input logic w, input logic [7:0] d, input logic [7:0] s);
    exp_t e;
    e.w = w; e.d = d; e.s = s;
    return e;
  endfunction

  // Monitor: after each edge, pop the expected outputs and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 3;
        if (bus.wout !== e.w) begin
          failures++;
          $display("FAIL wout got=%0b exp=%0b t=%0t", bus.wout, e.w, $time);
        end
        if (bus.dout !== e.d) begin
          failures++;
          $display("FAIL dout got=%02h exp=%02h t=%0t", bus.dout, e.d, $time);
        end
        if (bus.status_out !== e.s) begin
          failures++;
          $display("FAIL status got=%02h exp=%02h t=%0t", bus.status_out, e.s, $time);
        end
        $display("txn w=%0b dout=%02h status=%02h", bus.wout, bus.dout, bus.status_out);
      end
    end
  end

  initial begin
    logic       r, inv, cen;
    logic [7:0] f, a, b, st;
    exp_t       e;
    reset = 1'b1;
    bus.func = 8'h00; bus.a_in = 8'h00; bus.b_in = 8'h00;
    bus.invert = 1'b0; bus.carry_in = 1'b0; bus.status_in = 8'h00;

    // Directed cases with hand-derived expectations
    drive(1, 8'h01, 8'h12, 8'h34, 0, 0, 8'hFF, mk(0, 8'h00, 8'h00));
    drive(0, 8'h00, 8'h55, 8'h66, 0, 0, 8'hFF, mk(0, 8'h00, 8'h00));
    drive(0, 8'h00, 8'h77, 8'h88, 0, 0, 8'h00, mk(0, 8'h00, 8'h00));
    drive(0, 8'h01, 8'h50, 8'h50, 0, 0, 8'h00, mk(1, 8'hA0, 8'hC0));
    drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, mk(0, 8'hA0, 8'hC0));
    drive(0, 8'h01, 8'h00, 8'h01, 1, 1, 8'h01, mk(1, 8'hFF, 8'h80));
    drive(0, 8'h08, 8'h01, 8'h00, 0, 0, 8'h01, mk(1, 8'h80, 8'h81));
    drive(0, 8'h05, 8'h80, 8'h00, 0, 0, 8'h00, mk(1, 8'h00, 8'h03));
    drive(0, 8'h0B, 8'h10, 8'h10, 1, 1, 8'h00, mk(1, 8'h00, 8'h03));
    drive(0, 8'h0C, 8'h0F, 8'hC0, 0, 0, 8'h00, mk(1, 8'h0F, 8'hC2));
    drive(0, 8'h02, 8'hF0, 8'h0F, 0, 0, 8'h0C, mk(1, 8'h00, 8'h0E));
    drive(0, 8'hFF, 8'h12, 8'h34, 0, 0, 8'h00, mk(0, 8'h00, 8'h0E));

    // Randomized traffic, including undefined codes and mid-stream resets
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      f   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13));
      a   = 8'($urandom);
      b   = 8'($urandom);
      inv = 1'($urandom);
      cen = 1'($urandom);
      st  = 8'($urandom);
      e   = model(r, f, a, b, inv, cen, st, m);
      drive(r, f, a, b, inv, cen, st, e);
    end

    @(negedge clk);
    reset = 1'b0;
    bus.func = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_alu.md
Name: nes_alu

Overview:
- 8-bit 6502-style arithmetic/logic unit for the CPU core. It sits between the data bus (operands a_in/b_in) and the STATUS register and decoder.
- Takes an operation code from the decoder and computes the result plus updated N/V/Z/C flags.
- Registers both and pulses a one-cycle done strobe back to the decoder.
- No decimal mode (2A03 behaviour: D flag is ignored).

Parameters:
- DATA_WIDTH, 8, operand/result width. Only 8 is supported; the flag positions assume 8 bits.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- func  in  8  operation code (see Behaviour); 8'h00 = NOP
- a_in  in  8  operand A
- b_in  in  8  operand B
- invert  in  1  when 1, operand B is replaced by ~b_in before use
- carry_in  in  1  when 1, carry-in = status_in[CARRY]; when 0, carry-in = 0
- status_in  in  8  current STATUS register value
- dout  out  8  registered result
- status_out  out  8  registered updated status
- wout  out  1  done strobe, high for exactly one cycle per accepted op

Behaviour:
- Status bit indices: CARRY=0, ZERO=1, IRQ=2, DEC=3, BRK=4, (5 unused), OVF=6, NEG=7.
- Bits not listed as affected by an op are copied from status_in unchanged.
- Internal operands: B' = invert ? ~b_in : b_in; Cin = carry_in & status_in[CARRY].
- Ops, result R, flags affected:
  - 01 ADD: R = A + B' + Cin. C = bit-8 carry out; V = (A[7]==B'[7]) & (R[7]!=A[7]); N, Z.
  - 02 AND: R = A & B'. N, Z.
  - 03 OR: R = A | B'. N, Z.
  - 04 EOR: R = A ^ B'. N, Z.
  - 05 ASL: R = {A[6:0],0}. C = A[7]; N, Z.
  - 06 LSR: R = {0,A[7:1]}. C = A[0]; N = 0; Z.
  - 07 ROL: R = {A[6:0],status_in[C]}. C = A[7]; N, Z.
  - 08 ROR: R = {status_in[C],A[7:1]}. C = A[0]; N, Z.
  - 09 INC: R = A + 1 (mod 256). N, Z; C unchanged.
  - 0A DEC: R = A - 1 (mod 256). N, Z; C unchanged.
  - 0B CMP: R = A + ~b_in + 1, regardless of invert/carry_in. C = (A >= B unsigned); Z = (A == B); N = R[7]; V unchanged.
  - 0C BIT: R = A. Z = ((A & b_in) == 0); N = b_in[7]; V = b_in[6].
  - 0D PASS: R = B'. N, Z.
- Z is always (R == 0) and N is always R[7] unless an op above states otherwise.
- SBC is issued as ADD with invert=1, carry_in=1.
- Timing: func is sampled every rising edge.
  - Valid non-NOP func at edge k: dout and status_out load at edge k, wout = 1 during cycle k..k+1.
  - NOP or undefined code: dout and status_out hold their values, wout = 0.
- Back-to-back ops are allowed; each valid cycle produces a new result and wout stays high across consecutive valid cycles.
- Reset (synchronous, active-high, priority over func): dout = 8'h00, status_out = 8'h00, wout = 0.
- Reset asserted mid-operation discards the pending result.
- Wrap-around: all 8-bit arithmetic is mod 256; carry/overflow are reported only via flags.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ALU op-code constants (ALU_NOP..ALU_PASS)
  - status bit indices (CARRY, ZERO, IRQ, DEC, BRK, OVF, NEG)
  - DATA_WIDTH
- One natural sub-module: nes_alu_adder, a combinational 8-bit adder returning {carry_out, sum, overflow}. It is shared by ADD, CMP, INC and DEC.

Test Plan:
- Reset: reset=1 for 1 cycle with func=01 -> dout=00, status_out=00, wout=0. Then func=00 for 2 cycles -> outputs hold, wout=0.
- ADD overflow: a=50, b=50, status_in=00, carry_in=0 -> dout=A0, N=1, V=1, C=0, Z=0, wout=1 for one cycle.
- SBC borrow: func=01, invert=1, carry_in=1, status_in[C]=1, a=00, b=01 -> dout=FF, C=0, N=1, Z=0.
- Shift/rotate: ROR with a=01, status_in[C]=1 -> dout=80, C=1, N=1. Then ASL with a=80 -> dout=00, C=1, Z=1.
- CMP/BIT: CMP a=10, b=10 -> Z=1, C=1, N=0. BIT a=0F, b=C0 -> dout=0F, Z=1, N=1, V=1.
- Passthrough and undefined ops: status_in=0C, AND a=F0, b=0F -> status_out bits 2,3 still set, Z=1. func=FF -> wout=0 and outputs unchanged.
